// File: rtl/rwt_axis_pkg.sv
// Shared types and constants for the AXI-Stream packetizer and its skid buffer.
package rwt_axis_pkg;

    localparam int DEFAULT_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rwt_axis_skid.sv
// Two-entry registered skid buffer. The head entry drives the read side directly,
// so everything it presents downstream comes straight from flops.
module rwt_axis_skid #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    logic         head_valid;
    logic [W-1:0] head_data;
    logic         spare_valid;
    logic [W-1:0] spare_data;
    logic         push;

    // The spare entry can only hold data while the head is also full.
    assign wr_ready = !spare_valid;
    assign push     = wr_valid && wr_ready;
    assign rd_valid = head_valid;
    assign rd_data  = head_data;
    assign empty    = !head_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_valid  <= 1'b0;
            head_data   <= '0;
            spare_valid <= 1'b0;
            spare_data  <= '0;
        end else if (spare_valid) begin
            if (rd_ready) begin
                head_data   <= spare_data;
                spare_valid <= 1'b0;
            end
        end else if (head_valid) begin
            if (rd_ready) begin
                if (push) begin
                    head_data <= wr_data;
                end else begin
                    head_valid <= 1'b0;
                end
            end else if (push) begin
                spare_data  <= wr_data;
                spare_valid <= 1'b1;
            end
        end else if (push) begin
            head_data  <= wr_data;
            head_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/rwt_axis_packetizer.sv
// AXI-Stream packetizer: inserts tlast every len_q samples or on input tlast.
// Define RWT_AXIS_PACKETIZER_STATS_EN to add the pkt_count/trunc_count outputs.
module rwt_axis_packetizer
    import rwt_axis_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int UWIDTH = 1,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DWIDTH-1:0] s_axis_tdata,
    input  logic [UWIDTH-1:0] s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic [UWIDTH-1:0] m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              busy
`ifdef RWT_AXIS_PACKETIZER_STATS_EN
    ,
    output logic [31:0]       pkt_count,
    output logic [31:0]       trunc_count
`endif
);

    localparam int PW = DWIDTH + UWIDTH + 1;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic             len_hit;
    logic             is_last;
    logic             accept_ok;
    logic             accept;
    logic             skid_wr_ready;
    logic             skid_empty;
    logic [PW-1:0]    skid_rd_data;

    // cnt is zero only at a packet boundary, so the first sample sees pkt_len live.
    assign len_eff   = (cnt == '0) ? pkt_len : len_q;
    assign len_hit   = (len_eff != '0) && (cnt == len_eff - LEN_W'(1));
    assign is_last   = s_axis_tlast || len_hit;
    assign accept_ok = (state == RUN) || ((state == DRAIN) && (cnt != '0));
    assign s_axis_tready = accept_ok && skid_wr_ready;
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (cnt == '0) begin
                    len_q <= pkt_len;
                end
                if (is_last) begin
                    cnt <= '0;
                end else if (cnt != '1) begin
                    cnt <= cnt + LEN_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = ((cnt == '0) && !accept && skid_empty) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if ((cnt == '0) && skid_empty) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    rwt_axis_skid #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (accept),
        .wr_ready (skid_wr_ready),
        .wr_data  ({is_last, s_axis_tuser, s_axis_tdata}),
        .rd_valid (m_axis_tvalid),
        .rd_ready (m_axis_tready),
        .rd_data  (skid_rd_data),
        .empty    (skid_empty)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = skid_rd_data;

`ifdef RWT_AXIS_PACKETIZER_STATS_EN
    // A truncated packet is one closed by input tlast before its programmed length.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_count   <= '0;
            trunc_count <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (accept && s_axis_tlast && (len_eff != '0) && !len_hit) begin
                trunc_count <= trunc_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rwt_axis_packetizer.sv
// Directed + randomized bench for rwt_axis_packetizer against a packet-position model.
// Stats outputs are checked only when RWT_AXIS_PACKETIZER_STATS_EN is defined.
module tb_rwt_axis_packetizer;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic [15:0] pkt_len;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [0:0]  s_axis_tuser;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [0:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic        busy;
`ifdef RWT_AXIS_PACKETIZER_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] trunc_count;
`endif

    rwt_axis_packetizer #(
        .DWIDTH(32),
        .UWIDTH(1),
        .LEN_W (16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .pkt_len       (pkt_len),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy)
`ifdef RWT_AXIS_PACKETIZER_STATS_EN
        ,
        .pkt_count     (pkt_count),
        .trunc_count   (trunc_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Source/sink controls and the reference model state.
    bit          src_on = 0;
    bit          rnd_valid = 0;
    bit          rnd_ready = 0;
    bit          rnd_tlast = 0;
    bit          chk_ready = 0;
    int          nxt = 0;
    int          tlast_at = -1;
    int          n_acc = 0;
    int          pos = 0;
    int          plen = 0;
    int          pkt_exp = 0;
    int          trunc_exp = 0;
    bit          prev_stall = 0;
    logic [33:0] prev_pay = '0;
    logic [33:0] exp_q[$];
    int          tlast_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input int val);
        int got;
        got = (idx < tlast_log.size()) ? tlast_log[idx] : -1;
        check(tag, 64'(got), 64'(val));
    endtask

    // One clock: drive inputs at the falling edge, sample, update the model, advance.
    task automatic cycle();
        logic [33:0] pay;
        logic [33:0] exp;
        bit          last;
        s_axis_tvalid = src_on && (!rnd_valid || ($urandom_range(0, 3) != 0));
        s_axis_tdata  = 32'(nxt);
        s_axis_tuser  = 1'($urandom_range(0, 1));
        s_axis_tlast  = (nxt == tlast_at) || (rnd_tlast && ($urandom_range(0, 15) == 0));
        m_axis_tready = !rnd_ready || ($urandom_range(0, 2) != 0);
        #1;
        pay = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
        if (chk_ready) begin
            check("s_tready_vs_occupancy", 64'(s_axis_tready), 64'(exp_q.size() < 2));
        end
        if (prev_stall) begin
            check("stall_tvalid_held", 64'(m_axis_tvalid), 64'd1);
            check("stall_payload_held", 64'(pay), 64'(prev_pay));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("output_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                exp = exp_q.pop_front();
                check("out_payload", 64'(pay), 64'(exp));
                if (exp[33]) pkt_exp++;
                if (m_axis_tlast) tlast_log.push_back(int'(m_axis_tdata));
            end
        end
        if (s_axis_tvalid && s_axis_tready) begin
            if (pos == 0) plen = int'(pkt_len);
            last = s_axis_tlast || (plen != 0 && pos == plen - 1);
            if (s_axis_tlast && plen != 0 && pos != plen - 1) trunc_exp++;
            exp_q.push_back({last, s_axis_tuser, s_axis_tdata});
            pos = last ? 0 : pos + 1;
            nxt++;
            n_acc++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_pay   = pay;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until(input string tag, input int count, input int budget);
        int target;
        int c;
        target = n_acc + count;
        c = 0;
        while (n_acc < target && c < budget) begin
            cycle();
            c++;
        end
        check(tag, 64'(n_acc), 64'(target));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_m_tdata"},  64'(m_axis_tdata),  64'd0);
        check({tag, "_m_tuser"},  64'(m_axis_tuser),  64'd0);
        check({tag, "_m_tlast"},  64'(m_axis_tlast),  64'd0);
        check({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_busy"},     64'(busy),          64'd0);
`ifdef RWT_AXIS_PACKETIZER_STATS_EN
        check({tag, "_pkt_count"},   64'(pkt_count),   64'd0);
        check({tag, "_trunc_count"}, 64'(trunc_count), 64'd0);
`endif
    endtask

    task automatic clear_model();
        exp_q.delete();
        pos        = 0;
        plen       = 0;
        prev_stall = 0;
        pkt_exp    = 0;
        trunc_exp  = 0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn        = 1'b0;
        enable        = 1'b0;
        pkt_len       = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        resetn = 1'b1;

        // Fixed length 4, ten samples, then close the open packet with input tlast.
        pkt_len = 16'd4;
        enable  = 1'b1;
        src_on  = 1;
        nxt     = 0;
        check("A_tready_first_edge", 64'(s_axis_tready), 64'd0);
        cycle();
        check("A_tready_second_edge", 64'(s_axis_tready), 64'd1);
        run_until("A_accept", 10, 100);
        src_on = 0;
        idle_cycles(4);
        check("A_tlast_count", 64'(tlast_log.size()), 64'd2);
        check_log("A_tlast0", 0, 3);
        check_log("A_tlast1", 1, 7);
        check("A_pending", 64'(exp_q.size()), 64'd0);
        tlast_at = 10;
        src_on   = 1;
        run_until("A_close", 1, 20);
        src_on   = 0;
        tlast_at = -1;
        idle_cycles(4);
        check_log("A_close_tlast", 2, 10);

        // Input tlast on sample 1 truncates; the next packet counts from zero.
        tlast_log.delete();
        nxt      = 0;
        tlast_at = 1;
        src_on   = 1;
        run_until("B_accept", 6, 50);
        src_on   = 0;
        tlast_at = -1;
        idle_cycles(4);
        check("B_tlast_count", 64'(tlast_log.size()), 64'd2);
        check_log("B_tlast0", 0, 1);
        check_log("B_tlast1", 1, 5);
`ifdef RWT_AXIS_PACKETIZER_STATS_EN
        check("B_trunc_count", 64'(trunc_count), 64'(trunc_exp));
`endif

        // pkt_len changes mid-packet; only the following packet uses it.
        tlast_log.delete();
        nxt    = 0;
        src_on = 1;
        run_until("C_accept_a", 2, 20);
        pkt_len = 16'd2;
        run_until("C_accept_b", 4, 20);
        src_on = 0;
        idle_cycles(4);
        check("C_tlast_count", 64'(tlast_log.size()), 64'd2);
        check_log("C_tlast0", 0, 3);
        check_log("C_tlast1", 1, 5);

        // Enable drops mid-packet: the packet completes, then the block idles.
        begin
            int d_base;
            tlast_log.delete();
            nxt     = 0;
            pkt_len = 16'd8;
            d_base  = n_acc;
            src_on  = 1;
            run_until("D_accept", 3, 20);
            enable = 1'b0;
            idle_cycles(20);
            check("D_accepted", 64'(n_acc - d_base), 64'd8);
            check("D_busy", 64'(busy), 64'd0);
            check("D_s_tready", 64'(s_axis_tready), 64'd0);
            check("D_tlast_count", 64'(tlast_log.size()), 64'd1);
            check_log("D_tlast0", 0, 7);
            check("D_pending", 64'(exp_q.size()), 64'd0);
            src_on = 0;
        end

        // Random valid/ready/tlast and length changes over 1000 samples.
        enable  = 1'b1;
        pkt_len = 16'($urandom_range(1, 6));
        cycle();
        nxt       = 0;
        chk_ready = 1;
        rnd_valid = 1;
        rnd_ready = 1;
        rnd_tlast = 1;
        src_on    = 1;
        for (int seg = 0; seg < 10; seg++) begin
            pkt_len = 16'($urandom_range(0, 6));
            run_until("E_accept", 100, 2000);
        end
        src_on    = 0;
        chk_ready = 0;
        rnd_valid = 0;
        rnd_ready = 0;
        rnd_tlast = 0;
        idle_cycles(5);
        check("E_pending", 64'(exp_q.size()), 64'd0);
`ifdef RWT_AXIS_PACKETIZER_STATS_EN
        check("E_pkt_count", 64'(pkt_count), 64'(pkt_exp));
        check("E_trunc_count", 64'(trunc_count), 64'(trunc_exp));
`endif

        // Reset mid-packet discards the buffered samples and restarts cleanly.
        nxt     = 0;
        pkt_len = 16'd3;
        src_on  = 1;
        run_until("F_accept_pre", 2, 20);
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst1");
        clear_model();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst2");
        resetn = 1'b1;
        tlast_log.delete();
        nxt = 0;
        check("F_tready_first_edge", 64'(s_axis_tready), 64'd0);
        cycle();
        check("F_tready_second_edge", 64'(s_axis_tready), 64'd1);
        run_until("F_accept", 3, 20);
        src_on = 0;
        idle_cycles(4);
        check("F_tlast_count", 64'(tlast_log.size()), 64'd1);
        check_log("F_tlast0", 0, 2);
        check("F_pending", 64'(exp_q.size()), 64'd0);
`ifdef RWT_AXIS_PACKETIZER_STATS_EN
        check("F_pkt_count", 64'(pkt_count), 64'(pkt_exp));
        check("F_trunc_count", 64'(trunc_count), 64'(trunc_exp));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
